// File: rtl/adc_init_seq.sv
// adc_init_seq: power-up delay, then sends each ROM command word to the ADC serial engine with ack timeout and retry
module adc_init_seq #(
  parameter int          N_CMDS    = 8,
  parameter logic [15:0] PWR_DLY   = 16'd1000,
  parameter logic [7:0]  ACK_TMO   = 8'd200,
  parameter logic [1:0]  RETRY_MAX = 2'd3
) (
  input  logic        CLK,
  input  logic        EOS,
  input  logic        ADC_INIT_RST,
  output logic [3:0]  ROM_ADDR,
  input  logic [23:0] ROM_DATA,
  output logic        SER_REQ,
  output logic [23:0] SER_WORD,
  input  logic        SER_ACK,
  output logic        ADC_RDY,
  output logic        ADC_ERR,
  output logic [2:0]  INIT_STATE
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_PWR_DLY, ST_FETCH, ST_LOAD, ST_SEND, ST_NEXT, ST_DONE, ST_ERROR
  } state_t;
  state_t state, state_nx;
  logic [15:0] dly_cnt, dly_nx;
  logic [7:0] tmo_cnt, tmo_nx;
  logic [1:0] retry_cnt, retry_nx;
  logic [3:0] addr_nx;
  logic [23:0] word_nx;
  logic req_nx, rdy_nx, err_nx;
  assign INIT_STATE = state;
  // state, counters and every output are registered from the next-value logic
  always_ff @(posedge CLK or negedge EOS)
    if (!EOS) begin
      state     <= ST_IDLE;
      ROM_ADDR  <= '0;
      SER_REQ   <= 1'b0;
      SER_WORD  <= '0;
      ADC_RDY   <= 1'b0;
      ADC_ERR   <= 1'b0;
      dly_cnt   <= '0;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nx;
      ROM_ADDR  <= addr_nx;
      SER_REQ   <= req_nx;
      SER_WORD  <= word_nx;
      ADC_RDY   <= rdy_nx;
      ADC_ERR   <= err_nx;
      dly_cnt   <= dly_nx;
      tmo_cnt   <= tmo_nx;
      retry_cnt <= retry_nx;
    end
  // next state and next register values; ADC_INIT_RST overrides everything
  always_comb begin
    state_nx = state;
    addr_nx  = ROM_ADDR;
    req_nx   = SER_REQ;
    word_nx  = SER_WORD;
    rdy_nx   = ADC_RDY;
    err_nx   = ADC_ERR;
    dly_nx   = dly_cnt;
    tmo_nx   = tmo_cnt;
    retry_nx = retry_cnt;
    if (ADC_INIT_RST) begin
      state_nx = ST_IDLE;
      addr_nx  = '0;
      req_nx   = 1'b0;
      rdy_nx   = 1'b0;
      err_nx   = 1'b0;
      dly_nx   = '0;
      tmo_nx   = '0;
      retry_nx = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_PWR_DLY;
          dly_nx   = '0;
        end
        ST_PWR_DLY: begin
          dly_nx = dly_cnt + 16'd1;
          if (dly_cnt == PWR_DLY - 16'd1) begin
            state_nx = ST_FETCH;
            addr_nx  = '0;
            retry_nx = '0;
          end
        end
        ST_FETCH: state_nx = ST_LOAD;
        ST_LOAD: begin
          word_nx  = ROM_DATA;
          req_nx   = 1'b1;
          tmo_nx   = '0;
          state_nx = ST_SEND;
        end
        ST_SEND: begin
          tmo_nx = tmo_cnt + 8'd1;
          if (SER_ACK) begin
            state_nx = ST_NEXT;
            req_nx   = 1'b0;
          end else if (tmo_cnt == ACK_TMO - 8'd1) begin
            req_nx   = 1'b0;
            state_nx = retry_cnt == RETRY_MAX ? ST_ERROR : ST_FETCH;
            err_nx   = retry_cnt == RETRY_MAX;
            retry_nx = retry_cnt == RETRY_MAX ? retry_cnt : retry_cnt + 2'd1;
          end
        end
        ST_NEXT: begin
          if (ROM_ADDR == 4'(N_CMDS - 1)) begin
            state_nx = ST_DONE;
            rdy_nx   = 1'b1;
          end else begin
            state_nx = ST_FETCH;
            addr_nx  = ROM_ADDR + 4'd1;
            retry_nx = '0;
          end
        end
        ST_DONE: state_nx = ST_DONE;
        ST_ERROR: begin
          state_nx = ST_ERROR;
          req_nx   = 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc_init_seq.sv
// tb_adc_init_seq: table-driven, hand-written and randomized checks of adc_init_seq against a timeline model
module tb_adc_init_seq;
  localparam int N    = 8;
  localparam int PD   = 1000;
  localparam int TMO  = 200;
  localparam int RMAX = 3;
  typedef struct {
    string name;
    int    cmd;
    int    nfail;
    int    dlast;
    int    kind;
    int    end_off;
    int    nrise;
  } vec_t;
  logic CLK = 1'b0, EOS = 1'b0, ADC_INIT_RST = 1'b1, SER_ACK = 1'b0;
  logic [23:0] ROM_DATA = '0;
  logic [3:0] ROM_ADDR;
  logic SER_REQ, ADC_RDY, ADC_ERR;
  logic [23:0] SER_WORD;
  logic [2:0] INIT_STATE;
  int checks = 0, failures = 0;
  int cyc = 0;
  logic [23:0] rom [16];
  int plan [$];
  int pidx = 0, k = 0, d = 1;
  bit prev_req = 1'b0, spur = 1'b0;
  int rise_t [$];
  logic [23:0] rise_w [$];
  int exp_t [$];
  logic [23:0] exp_w [$];
  int end_t = -1, end_kind = 0, both_hi = 0;
  vec_t tbl [5];

  adc_init_seq dut (
    .CLK(CLK), .EOS(EOS), .ADC_INIT_RST(ADC_INIT_RST), .ROM_ADDR(ROM_ADDR),
    .ROM_DATA(ROM_DATA), .SER_REQ(SER_REQ), .SER_WORD(SER_WORD), .SER_ACK(SER_ACK),
    .ADC_RDY(ADC_RDY), .ADC_ERR(ADC_ERR), .INIT_STATE(INIT_STATE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    ROM_DATA <= rom[ROM_ADDR];
  end

  // serial engine model: acks each attempt after its planned delay (0 = never), logs request rises and completion
  initial forever begin
    @(posedge CLK);
    #1;
    if (SER_REQ && !prev_req) begin
      k = 0;
      rise_t.push_back(cyc);
      rise_w.push_back(SER_WORD);
      d = pidx < plan.size() ? plan[pidx] : 1;
      pidx++;
    end else if (SER_REQ) k++;
    SER_ACK = SER_REQ ? (d != 0 && k == d - 1) : (spur && $urandom_range(3) == 0);
    prev_req = SER_REQ;
    if (ADC_RDY && ADC_ERR) both_hi++;
    if ((ADC_RDY || ADC_ERR) && end_t < 0) begin
      end_t = cyc;
      end_kind = ADC_ERR ? 2 : 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // expected request timeline: each attempt rises 2 cycles after its fetch; ack at delay dd moves to the
  // next fetch dd+1 cycles after the rise, a timeout refetches TMO cycles after the rise
  task automatic model(input int c0, output int t_end, output int kind);
    int f = c0 + 1 + PD;
    int p = 0;
    int r, dd;
    exp_t.delete();
    exp_w.delete();
    t_end = -1;
    kind = 0;
    for (int c = 0; c < N; c++)
      for (int a = 0; a <= RMAX; a++) begin
        r = f + 2;
        exp_t.push_back(r);
        exp_w.push_back(rom[c]);
        dd = p < plan.size() ? plan[p] : 1;
        p++;
        if (dd != 0) begin
          f = r + dd + 1;
          if (c == N - 1) begin
            t_end = f;
            kind = 1;
          end
          break;
        end
        if (a == RMAX) begin
          t_end = r + TMO;
          kind = 2;
          return;
        end
        f = r + TMO;
      end
  endtask

  task automatic build_plan(input int cmd, input int nfail, input int dlast);
    plan.delete();
    for (int c = 0; c < N; c++)
      if (c == cmd) begin
        for (int a = 0; a < nfail; a++) plan.push_back(0);
        if (nfail <= RMAX) plan.push_back(dlast);
      end else plan.push_back(1);
  endtask

  task automatic hold(input int n);
    ADC_INIT_RST = 1'b1;
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic start(output int c0);
    rise_t.delete();
    rise_w.delete();
    end_t = -1;
    end_kind = 0;
    both_hi = 0;
    pidx = 0;
    @(posedge CLK);
    #2;
    c0 = cyc;
    ADC_INIT_RST = 1'b0;
  endtask

  task automatic finish(input string nm, input int c0, input int exp_off);
    int mt, mk, lim, n;
    model(c0, mt, mk);
    lim = mt - cyc + 20;
    if (lim < 20) lim = 20;
    n = 0;
    while (end_t < 0 && n < lim) begin
      @(posedge CLK);
      #2;
      n++;
    end
    chk({nm, " end_kind"}, end_kind, mk);
    chk({nm, " end_cycle"}, end_t, mt);
    if (exp_off >= 0) chk({nm, " latency"}, end_t - c0, exp_off);
    chk({nm, " n_requests"}, rise_t.size(), exp_t.size());
    for (int i = 0; i < exp_t.size() && i < rise_t.size(); i++) begin
      chk($sformatf("%s req%0d_cycle", nm, i), rise_t[i], exp_t[i]);
      chk($sformatf("%s req%0d_word", nm, i), rise_w[i], exp_w[i]);
    end
    repeat (5) @(posedge CLK);
    #2;
    chk({nm, " rdy_err_both"}, both_hi, 0);
    chk({nm, " final_state"}, INIT_STATE, mk == 2 ? 7 : 6);
    chk({nm, " final_rdy"}, ADC_RDY, mk == 1);
    chk({nm, " final_err"}, ADC_ERR, mk == 2);
    chk({nm, " final_req"}, SER_REQ, 0);
  endtask

  initial begin
    int c0, bad, n, nf;
    tbl[0] = '{"nominal",      -1, 0, 1,   1, 1033, 8};
    tbl[1] = '{"single_retry",  3, 1, 1,   1, 1235, 9};
    tbl[2] = '{"exhaust",       0, 4, 1,   2, 1809, 4};
    tbl[3] = '{"collision",     2, 0, 200, 1, 1232, 8};
    tbl[4] = '{"max_retry_ok",  7, 3, 1,   1, 1639, 11};
    for (int i = 0; i < 16; i++) rom[i] = 24'hA00000 + 24'(i);

    repeat (2) @(posedge CLK);
    #2;
    chk("reset state", INIT_STATE, 0);
    chk("reset addr", ROM_ADDR, 0);
    chk("reset req", SER_REQ, 0);
    chk("reset word", SER_WORD, 0);
    chk("reset rdy", ADC_RDY, 0);
    chk("reset err", ADC_ERR, 0);
    EOS = 1'b1;
    bad = 0;
    repeat (50) begin
      @(posedge CLK);
      #2;
      if (INIT_STATE != 0 || SER_REQ || ADC_RDY) bad++;
    end
    chk("hold idle violations", bad, 0);

    foreach (tbl[i]) begin
      build_plan(tbl[i].cmd, tbl[i].nfail, tbl[i].dlast);
      hold(3);
      start(c0);
      finish(tbl[i].name, c0, tbl[i].end_off);
      chk({tbl[i].name, " kind"}, end_kind, tbl[i].kind);
      chk({tbl[i].name, " nrise"}, rise_t.size(), tbl[i].nrise);
      if (rise_t.size() > 0) chk({tbl[i].name, " first_req"}, rise_t[0] - c0, 1 + PD + 2);
    end

    build_plan(5, 4, 1);
    hold(3);
    start(c0);
    n = 0;
    while (!(SER_REQ && SER_WORD == rom[5]) && n < 3000) begin
      @(posedge CLK);
      #2;
      n++;
    end
    chk("abort reached cmd5", SER_REQ && SER_WORD == rom[5], 1);
    repeat (20) @(posedge CLK);
    #2;
    ADC_INIT_RST = 1'b1;
    @(posedge CLK);
    #2;
    chk("abort req", SER_REQ, 0);
    chk("abort state", INIT_STATE, 0);
    chk("abort addr", ROM_ADDR, 0);
    build_plan(-1, 0, 1);
    hold(3);
    start(c0);
    finish("restart", c0, 1033);

    hold(3);
    start(c0);
    repeat (10) @(posedge CLK);
    #2;
    chk("pre_eos state", INIT_STATE, 1);
    #1 EOS = 1'b0;
    #1 chk("async eos state", INIT_STATE, 0);
    @(posedge CLK);
    #2 EOS = 1'b1;

    spur = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) rom[i] = 24'($urandom);
      plan.delete();
      for (int c = 0; c < N; c++) begin
        nf = $urandom_range(0, 5) == 0 ? $urandom_range(1, 4) : 0;
        for (int a = 0; a < nf; a++) plan.push_back(0);
        if (nf <= RMAX) plan.push_back($urandom_range(0, 3) == 0 ? $urandom_range(1, 200) : $urandom_range(1, 3));
      end
      hold(3);
      start(c0);
      finish($sformatf("rand%0d", r), c0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
